// File: rtl/key_scan_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, frame
// classification and the column drive pattern loaded at reset.
package key_scan_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED,
      RELEASE_DEB
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } frame_class_t;

   localparam logic [3:0] COL_INIT = 4'b1110;

endpackage

// File: rtl/key_scan_tick.sv
// Column-step divider: counts 0..SCAN_DIV-1 and flags the last count as a
// one-cycle tick.
module key_scan_tick #(
   parameter int SCAN_DIV = 25000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = $clog2(SCAN_DIV);
   localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

   logic [W-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner with frame-level debounce and a one-deep key holding
// register. Define KEY_SCAN_SYNC_EN to pass row through a two-flop synchronizer.
module key_scan
   import key_scan_pkg::*;
#(
   parameter int SCAN_DIV = 25000,
   parameter int DEB_CNT  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_down,
   output logic       overrun
);

   localparam logic [3:0] DEB = 4'(DEB_CNT);

   logic         tick;
   logic [1:0]   col_idx;
   logic [11:0]  snap;
   logic [15:0]  frame;
   logic         eval;
   logic [4:0]   ones;
   logic [3:0]   fcode;
   frame_class_t fclass;

   state_t       state, next_state;
   logic [3:0]   cnt, next_cnt;
   logic [3:0]   cand, next_cand;
   logic         accept;

   key_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

`ifdef KEY_SCAN_SYNC_EN
   logic [3:0] row_m, row_s;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_m <= '1;
         row_s <= '1;
      end else begin
         row_m <= row;
         row_s <= row_m;
      end
   end
`else
   logic [3:0] row_s;
   assign row_s = row;
`endif

   // Snapshot stores pressed keys as 1; the fourth column is taken live at evaluation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col     <= COL_INIT;
         col_idx <= '0;
         snap    <= '0;
      end else if (tick) begin
         col     <= {col[2:0], col[3]};
         col_idx <= col_idx + 2'd1;
         case (col_idx)
            2'd0:    snap[3:0]  <= ~row_s;
            2'd1:    snap[7:4]  <= ~row_s;
            2'd2:    snap[11:8] <= ~row_s;
            default: ;
         endcase
      end
   end

   assign eval  = tick && (col_idx == 2'd3);
   assign frame = {~row_s, snap};

   // Bit index within the frame equals {col_index, row_index}.
   always_comb begin
      ones  = '0;
      fcode = '0;
      for (int i = 0; i < 16; i++) begin
         if (frame[i]) begin
            ones  = ones + 5'd1;
            fcode = 4'(i);
         end
      end
      if (ones == 5'd0) begin
         fclass = NONE;
      end else if (ones == 5'd1) begin
         fclass = SINGLE;
      end else begin
         fclass = MULTI;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         cand  <= next_cand;
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_cand  = cand;
      accept     = 1'b0;
      if (eval) begin
         case (state)
            IDLE: begin
               if (fclass == SINGLE) begin
                  next_state = DEBOUNCE;
                  next_cnt   = 4'd1;
                  next_cand  = fcode;
               end
            end
            DEBOUNCE: begin
               if (fclass == SINGLE && fcode == cand) begin
                  if (cnt + 4'd1 == DEB) begin
                     next_state = PRESSED;
                     next_cnt   = '0;
                     accept     = 1'b1;
                  end else begin
                     next_cnt = cnt + 4'd1;
                  end
               end else begin
                  next_state = IDLE;
                  next_cnt   = '0;
               end
            end
            PRESSED: begin
               if (fclass == NONE) begin
                  next_state = RELEASE_DEB;
                  next_cnt   = 4'd1;
               end
            end
            RELEASE_DEB: begin
               if (fclass == NONE) begin
                  if (cnt + 4'd1 == DEB) begin
                     next_state = IDLE;
                     next_cnt   = '0;
                  end else begin
                     next_cnt = cnt + 4'd1;
                  end
               end else begin
                  next_state = PRESSED;
                  next_cnt   = '0;
               end
            end
            default: begin
               next_state = IDLE;
               next_cnt   = '0;
            end
         endcase
      end
   end

   assign key_down = (state == PRESSED) || (state == RELEASE_DEB);

   // A simultaneous ack frees the register, so the new key is loaded, not dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (accept) begin
         if (!key_valid || key_ack) begin
            key_code  <= cand;
            key_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (key_ack) begin
         key_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan (SCAN_DIV=4, DEB_CNT=3): frame-level vector table,
// reset corner sequences, and random frames against a frame-level model.
module tb_key_scan;
   import key_scan_pkg::*;

   localparam int DEB = 3;

   typedef struct {
      logic [15:0] keys;
      int          ack_at;
      logic        valid;
      logic [3:0]  code;
      logic        down;
      logic        ovr;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ack;
   logic        key_down;
   logic        overrun;
   logic [15:0] keys_v;

   int checks;
   int errors;
   vec_t tbl[$];

   key_scan #(.SCAN_DIV(4), .DEB_CNT(DEB)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ack   (key_ack),
      .key_down  (key_down),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad: a pressed key at bit col*4+row pulls that row low while its column is driven.
   function automatic logic [3:0] row_of(input logic [3:0] c, input logic [15:0] k);
      logic [3:0] r;
      r = 4'b1111;
      for (int ci = 0; ci < 4; ci++) begin
         if (c[ci] == 1'b0) begin
            for (int ri = 0; ri < 4; ri++) begin
               if (k[ci*4 + ri]) r[ri] = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign row = row_of(col, keys_v);

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called at a negedge aligned to a frame start; returns at the negedge after 16 posedges.
   task automatic run_frame(input logic [15:0] k, input int ack_at);
      keys_v = k;
      for (int i = 0; i < 16; i++) begin
         key_ack = (i == ack_at);
         @(posedge clk);
         @(negedge clk);
      end
      key_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic add(input logic [15:0] k, input int a, input logic v, input logic [3:0] c,
                      input logic d, input logic o);
      vec_t e;
      e.keys = k; e.ack_at = a; e.valid = v; e.code = c; e.down = d; e.ovr = o;
      tbl.push_back(e);
   endtask

   // Frame-level reference: streak counting of consecutive qualifying frames.
   logic       m_valid, m_down, m_ovr;
   logic [3:0] m_code, s_code;
   int         streak;

   task automatic model_frame(input logic [15:0] k, input int ack_at);
      int n;
      logic [3:0] code;
      logic acc;
      acc = 1'b0;
      n = $countones(k);
      code = '0;
      for (int b = 0; b < 16; b++) if (k[b]) code = 4'(b);
      if (ack_at >= 0 && ack_at < 15) m_valid = 1'b0;
      if (!m_down) begin
         if (n == 1 && streak > 0 && code == s_code) streak++;
         else if (n == 1 && streak == 0) begin
            streak = 1;
            s_code = code;
         end else streak = 0;
         if (streak == DEB) begin
            m_down = 1'b1;
            streak = 0;
            acc = 1'b1;
         end
      end else begin
         if (n == 0) streak++;
         else streak = 0;
         if (streak == DEB) begin
            m_down = 1'b0;
            streak = 0;
         end
      end
      if (acc) begin
         if (!m_valid || ack_at == 15) begin
            m_valid = 1'b1;
            m_code  = s_code;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (ack_at == 15) begin
         m_valid = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] prev, mk;
      int sel, a, ack_at;
      checks = 0;
      errors = 0;
      keys_v = '0;
      key_ack = 1'b0;
      rst = 1'b1;

      // keys, ack_at, valid, code, down, overrun
      add(16'h0200, -1, 0, 4'h0, 0, 0);
      add(16'h0200, -1, 0, 4'h0, 0, 0);
      add(16'h0200, -1, 1, 4'h9, 1, 0);
      add(16'h0200,  5, 0, 4'h9, 1, 0);
      add(16'h0000, -1, 0, 4'h9, 1, 0);
      add(16'h0000, -1, 0, 4'h9, 1, 0);
      add(16'h0000, -1, 0, 4'h9, 0, 0);
      add(16'h0200, -1, 0, 4'h9, 0, 0);
      add(16'h0200, -1, 0, 4'h9, 0, 0);
      add(16'h0000, -1, 0, 4'h9, 0, 0);
      add(16'h0200, -1, 0, 4'h9, 0, 0);
      add(16'h0200, -1, 0, 4'h9, 0, 0);
      add(16'h0000, -1, 0, 4'h9, 0, 0);
      for (int i = 0; i < 5; i++) add(16'h8001, -1, 0, 4'h9, 0, 0);
      add(16'h0200, -1, 0, 4'h9, 0, 0);
      add(16'h0200, -1, 0, 4'h9, 0, 0);
      add(16'h0200, -1, 1, 4'h9, 1, 0);
      add(16'h0000, -1, 1, 4'h9, 1, 0);
      add(16'h0000, -1, 1, 4'h9, 1, 0);
      add(16'h0000, -1, 1, 4'h9, 0, 0);
      add(16'h0008, -1, 1, 4'h9, 0, 0);
      add(16'h0008, -1, 1, 4'h9, 0, 0);
      add(16'h0008, -1, 1, 4'h9, 1, 1);
      add(16'h0000, -1, 1, 4'h9, 1, 1);
      add(16'h0000, -1, 1, 4'h9, 1, 1);
      add(16'h0000, -1, 1, 4'h9, 0, 1);
      add(16'h0008, -1, 1, 4'h9, 0, 1);
      add(16'h0008, -1, 1, 4'h9, 0, 1);
      add(16'h0008, 15, 1, 4'h3, 1, 1);
      add(16'h0008,  4, 0, 4'h3, 1, 1);

      #1 rst = 1'b0;
      #1;
      chk("init_col", col, 4'b1110);
      chk("init_valid", {3'b0, key_valid}, 4'h0);
      chk("init_down", {3'b0, key_down}, 4'h0);
      chk("init_code", key_code, 4'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         run_frame(tbl[i].keys, tbl[i].ack_at);
         chk($sformatf("vec%0d_valid", i), {3'b0, key_valid}, {3'b0, tbl[i].valid});
         chk($sformatf("vec%0d_code", i), key_code, tbl[i].code);
         chk($sformatf("vec%0d_down", i), {3'b0, key_down}, {3'b0, tbl[i].down});
         chk($sformatf("vec%0d_ovr", i), {3'b0, overrun}, {3'b0, tbl[i].ovr});
      end

      // Asynchronous reset in the middle of a column step with key held and overrun set.
      repeat (6) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_col", col, 4'b1110);
      chk("arst_code", key_code, 4'h0);
      chk("arst_valid", {3'b0, key_valid}, 4'h0);
      chk("arst_down", {3'b0, key_down}, 4'h0);
      chk("arst_ovr", {3'b0, overrun}, 4'h0);
      @(negedge clk);
      rst = 1'b1;

      // Reset with two debounce frames already counted: three fresh frames are needed.
      run_frame(16'h0200, -1);
      run_frame(16'h0200, -1);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_frame(16'h0200, -1);
      chk("rdeb_f1_valid", {3'b0, key_valid}, 4'h0);
      run_frame(16'h0200, -1);
      chk("rdeb_f2_valid", {3'b0, key_valid}, 4'h0);
      chk("rdeb_f2_down", {3'b0, key_down}, 4'h0);
      run_frame(16'h0200, -1);
      chk("rdeb_f3_valid", {3'b0, key_valid}, 4'h1);
      chk("rdeb_f3_code", key_code, 4'h9);

      // Random frames against the frame-level model.
      do_reset();
      m_valid = 1'b0; m_down = 1'b0; m_ovr = 1'b0;
      m_code = '0; s_code = '0; streak = 0;
      prev = '0;
      for (int f = 0; f < 80; f++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4) mk = prev;
         else if (sel < 6) mk = '0;
         else if (sel < 9) mk = 16'd1 << $urandom_range(0, 15);
         else mk = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
         a = $urandom_range(0, 5);
         ack_at = (a == 0) ? 15 : (a == 1) ? int'($urandom_range(2, 12)) : -1;
         prev = mk;
         run_frame(mk, ack_at);
         model_frame(mk, ack_at);
         chk($sformatf("rnd%0d_valid", f), {3'b0, key_valid}, {3'b0, m_valid});
         chk($sformatf("rnd%0d_code", f), key_code, m_code);
         chk($sformatf("rnd%0d_down", f), {3'b0, key_down}, {3'b0, m_down});
         chk($sformatf("rnd%0d_ovr", f), {3'b0, overrun}, {3'b0, m_ovr});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
